// File: rtl/keypad_digit_display.sv
// Keypad receive path: debounces {valid,bcd} codes, shifts accepted digits into a
// DIGITS-deep buffer and scans it onto a multiplexed 7-segment display.
// Optional build macro KEYPAD_LZB_EN enables leading-zero blanking.
module keypad_digit_display #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned DEBOUNCE = 4,
  parameter int unsigned SCAN_DIV = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        code_in,
  input  logic              clr,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an,
  output logic              digit_strobe,
  output logic              err,
  output logic [2:0]        count,
  output logic              overflow
);

  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DB_W  = $clog2(DEBOUNCE + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DEBOUNCE,
    ST_HELD
  } state_t;

  state_t            state_q, state_n;
  logic [3:0]        latch_q, latch_n;
  logic [DB_W-1:0]   cnt_q, cnt_n;
  logic              accept_c;

  logic [3:0]        digit_buf_q [DIGITS];
  logic [3:0]        digit_buf_n [DIGITS];
  logic [2:0]        count_n;
  logic              overflow_n;
  logic              strobe_n;
  logic              err_n;

  logic [PRE_W-1:0]  pre_q, pre_n;
  logic [IDX_W-1:0]  idx_q, idx_n;
  logic [DIGITS-1:0] an_n;
  logic [6:0]        seg_n;

  wire               key_valid = code_in[4];
  wire  [3:0]        key_code  = code_in[3:0];

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // Debounce FSM: a code must be sampled unchanged for DEBOUNCE edges after the latch edge.
  always_comb begin
    state_n  = state_q;
    latch_n  = latch_q;
    cnt_n    = cnt_q;
    accept_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (key_valid) begin
          latch_n = key_code;
          cnt_n   = DB_W'(1);
          state_n = ST_DEBOUNCE;
        end
      end
      ST_DEBOUNCE: begin
        if (!key_valid) begin
          state_n = ST_IDLE;
        end else if (key_code != latch_q) begin
          latch_n = key_code;
          cnt_n   = DB_W'(1);
        end else if (cnt_q == DB_W'(DEBOUNCE)) begin
          state_n  = ST_HELD;
          accept_c = 1'b1;
        end else begin
          cnt_n = cnt_q + DB_W'(1);
        end
      end
      ST_HELD: begin
        if (!key_valid) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Buffer update; clr takes priority over a coincident push.
  always_comb begin
    logic is_digit;
    logic push;
    is_digit    = (latch_q <= 4'd9);
    push        = accept_c && is_digit && !clr;
    strobe_n    = push;
    err_n       = accept_c && !is_digit;
    digit_buf_n = digit_buf_q;
    count_n     = count;
    overflow_n  = overflow;
    if (clr) begin
      for (int i = 0; i < int'(DIGITS); i++) digit_buf_n[i] = 4'd0;
      count_n    = 3'd0;
      overflow_n = 1'b0;
    end else if (push) begin
      for (int i = int'(DIGITS) - 1; i > 0; i--) digit_buf_n[i] = digit_buf_q[i-1];
      digit_buf_n[0] = latch_q;
      if (count == 3'(DIGITS)) overflow_n = 1'b1;
      else                     count_n    = count + 3'd1;
    end
  end

  // Scan step; an/seg are registered from next-state values so they always match the buffer.
  always_comb begin
    pre_n = pre_q;
    idx_n = idx_q;
    if (pre_q == PRE_W'(SCAN_DIV - 1)) begin
      pre_n = '0;
      idx_n = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end else begin
      pre_n = pre_q + PRE_W'(1);
    end
    an_n  = DIGITS'(1) << idx_n;
    seg_n = seg_decode(digit_buf_n[idx_n]);
`ifdef KEYPAD_LZB_EN
    if ((idx_n != '0) && (3'(idx_n) >= count_n)) seg_n = 7'h00;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      latch_q      <= 4'd0;
      cnt_q        <= '0;
      for (int i = 0; i < int'(DIGITS); i++) digit_buf_q[i] <= 4'd0;
      count        <= 3'd0;
      overflow     <= 1'b0;
      digit_strobe <= 1'b0;
      err          <= 1'b0;
      pre_q        <= '0;
      idx_q        <= '0;
      an           <= DIGITS'(1);
      seg          <= 7'h3F;
    end else begin
      state_q      <= state_n;
      latch_q      <= latch_n;
      cnt_q        <= cnt_n;
      digit_buf_q  <= digit_buf_n;
      count        <= count_n;
      overflow     <= overflow_n;
      digit_strobe <= strobe_n;
      err          <= err_n;
      pre_q        <= pre_n;
      idx_q        <= idx_n;
      an           <= an_n;
      seg          <= seg_n;
    end
  end

endmodule
